// File: rtl/uart_rx_mv.sv
// UART receiver: 2-FF synchroniser, 3-sample majority vote, false-start and framing checks.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_mv #(
    parameter int DBIT = 8,
    parameter int OVS  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_tick,
    input  logic            rx,
    output logic            rx_done_tick,
    output logic [DBIT-1:0] dout,
    output logic            frame_err,
    output logic            parity_err
);

    localparam int SW = $clog2(OVS);
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [SW-1:0] S_LO   = SW'(OVS/2 - 2);
    localparam logic [SW-1:0] S_MID1 = SW'(OVS/2 - 1);
    localparam logic [SW-1:0] S_MID  = SW'(OVS/2);
    localparam logic [SW-1:0] S_LAST = SW'(OVS - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BRK    = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic            rx_meta, rxs;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] sh_q, sh_d;
    logic [1:0]      samp_q, samp_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            ferr_q, ferr_d;
    logic            done_q, done_d;
    logic            vote;
    logic            mid_tick;
    logic            last_tick;
`ifdef UART_RX_PARITY_EN
    logic            par_q, par_d;
    logic            perr_q, perr_d;
`endif

    // Two earlier samples are held; the third is the live rxs at the mid tick.
    assign vote = (samp_q[0] & samp_q[1]) |
                  (samp_q[0] & rxs) |
                  (samp_q[1] & rxs);

    assign mid_tick  = s_tick && (s_q == S_MID);
    assign last_tick = s_tick && (s_q == S_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            sh_q    <= '0;
            samp_q  <= '0;
            dout_q  <= '0;
            ferr_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            sh_q    <= sh_d;
            samp_q  <= samp_d;
            dout_q  <= dout_d;
            ferr_q  <= ferr_d;
            done_q  <= done_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        sh_d    = sh_q;
        samp_d  = samp_q;
        dout_d  = dout_q;
        ferr_d  = ferr_q;
        done_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = perr_q;
`endif

        if (s_tick && (s_q == S_LO)) begin
            samp_d[0] = rxs;
        end
        if (s_tick && (s_q == S_MID1)) begin
            samp_d[1] = rxs;
        end

        unique case (state_q)
            IDLE: begin
                if (!rxs) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (mid_tick && vote) begin
                    state_d = IDLE;
                    s_d     = '0;
                end else if (last_tick) begin
                    state_d = DATA;
                    s_d     = '0;
                    n_d     = '0;
                end else if (s_tick) begin
                    s_d = s_q + SW'(1);
                end
            end
            DATA: begin
                if (mid_tick) begin
                    sh_d = {vote, sh_q[DBIT-1:1]};
                end
                if (last_tick) begin
                    s_d = '0;
                    if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        n_d = n_q + NW'(1);
                    end
                end else if (s_tick) begin
                    s_d = s_q + SW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (mid_tick) begin
                    par_d = vote;
                end
                if (last_tick) begin
                    state_d = STOP;
                    s_d     = '0;
                end else if (s_tick) begin
                    s_d = s_q + SW'(1);
                end
            end
`endif
            STOP: begin
                // Decide at mid stop bit so a following start edge is not missed.
                if (mid_tick) begin
                    dout_d  = sh_q;
                    ferr_d  = ~vote;
                    done_d  = 1'b1;
                    s_d     = '0;
                    state_d = vote ? IDLE : BRK;
`ifdef UART_RX_PARITY_EN
                    perr_d  = (par_q != ^sh_q);
`endif
                end else if (s_tick) begin
                    s_d = s_q + SW'(1);
                end
            end
            BRK: begin
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                s_d     = '0;
            end
        endcase
    end

    assign rx_done_tick = done_q;
    assign dout         = dout_q;
    assign frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err   = perr_q;
`else
    assign parity_err   = 1'b0;
`endif

endmodule
